// File: rtl/cpu_controller.sv
// Control half of the CPU datapath: holds the instruction register, decodes it and
// sequences one MOV/ALU instruction per start request through a Moore FSM.
module cpu_controller #(
    parameter int W  = 16,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          load,
    input  logic [W-1:0]  in,
    output logic          w,
    output logic [1:0]    vsel,
    output logic [RW-1:0] readnum,
    output logic [RW-1:0] writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [W-1:0]  sximm5,
    output logic [W-1:0]  sximm8
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_ALU       = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    state_t state, state_nxt;
    logic [W-1:0] ir;

    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn, rd, rm;
    logic          is_mov_imm, is_mov_reg, is_mvn, is_cmp, is_two_src;

    function automatic logic signed [W-1:0] sext8(input logic signed [7:0] v);
        return {{(W-8){v[7]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sext5(input logic signed [4:0] v);
        return {{(W-5){v[4]}}, v};
    endfunction

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == OPC_MOV) && (op == 2'b10);
    assign is_mov_reg = (opcode == OPC_MOV) && (op == 2'b00);
    assign is_mvn     = (opcode == OPC_ALU) && (op == 2'b11);
    assign is_cmp     = (opcode == OPC_ALU) && (op == 2'b01);
    // ADD, CMP and AND read Rn as well as Rm
    assign is_two_src = (opcode == OPC_ALU) && (op != 2'b11);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_WAIT;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (load && state == ST_WAIT)
                ir <= in;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_WAIT:      state_nxt = s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm)                 state_nxt = ST_WRITE_IMM;
                else if (is_mov_reg || is_mvn)  state_nxt = ST_GET_B;
                else if (is_two_src)            state_nxt = ST_GET_A;
                else                            state_nxt = ST_WAIT;
            end
            ST_GET_A:     state_nxt = ST_GET_B;
            ST_GET_B:     state_nxt = ST_ALU;
            ST_ALU:       state_nxt = is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_nxt = ST_WAIT;
            ST_WRITE_IMM: state_nxt = ST_WAIT;
            default:      state_nxt = ST_WAIT;
        endcase
    end

    logic [RW-1:0] reg_idx;

    always_comb begin
        w       = 1'b0;
        vsel    = 2'b00;
        reg_idx = '0;
        write   = 1'b0;
        loada   = 1'b0;
        loadb   = 1'b0;
        loadc   = 1'b0;
        loads   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        unique case (state)
            ST_WAIT:  w = 1'b1;
            ST_GET_A: begin
                reg_idx = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                reg_idx = rm;
                loadb   = 1'b1;
            end
            ST_ALU: begin
                asel  = is_mov_reg || is_mvn;
                loads = is_cmp;
                loadc = !is_cmp;
            end
            ST_WRITE_REG: begin
                reg_idx = rd;
                write   = 1'b1;
            end
            ST_WRITE_IMM: begin
                vsel    = 2'b10;
                reg_idx = rn;
                write   = 1'b1;
            end
            default: ;
        endcase
    end

    assign readnum  = reg_idx;
    assign writenum = reg_idx;
    assign shift    = ir[4:3];
    assign ALUop    = (opcode == OPC_ALU) ? op : 2'b00;
    assign sximm5   = sext5(ir[4:0]);
    assign sximm8   = sext8(ir[7:0]);

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: MOV imm, ADD, CMP, MVN, NOP and reset abort,
// with hand-computed expectations checked by immediate assertions.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset, s, load;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, ALUop;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm5, sximm8;

    int checks = 0;
    int failures = 0;

    cpu_controller #(.W(16), .RW(3)) dut (
        .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
        .w(w), .vsel(vsel), .readnum(readnum), .writenum(writenum),
        .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
        .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
        .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe bundle {write,loada,loadb,loadc,loads} as one vector.
    function automatic logic [15:0] strobes();
        return {11'd0, write, loada, loadb, loadc, loads};
    endfunction

    initial begin
        // Reset dominates s/load in the same cycle
        reset = 1'b0; s = 1'b1; load = 1'b1; in = 16'hD007;
        step();
        chk("rst_w", {15'd0, w}, 16'd1);
        chk("rst_strobes", strobes(), 16'd0);
        chk("rst_vsel", {14'd0, vsel}, 16'd0);
        chk("rst_sximm8", sximm8, 16'h0000);
        reset = 1'b1; s = 1'b0; load = 1'b0;
        step();
        chk("rst_ir_held", sximm8, 16'h0000);
        chk("rst_w_idle", {15'd0, w}, 16'd1);

        // MOV R0,#7
        load = 1'b1; in = 16'hD007;
        step();
        chk("imm_loaded", sximm8, 16'h0007);
        load = 1'b0; s = 1'b1;
        step();
        chk("imm_decode_w", {15'd0, w}, 16'd0);
        chk("imm_decode_strobes", strobes(), 16'd0);
        s = 1'b0;
        step();
        chk("imm_write", strobes(), 16'b10000);
        chk("imm_vsel", {14'd0, vsel}, 16'b10);
        chk("imm_writenum", {13'd0, writenum}, 16'd0);
        chk("imm_sximm8", sximm8, 16'h0007);
        chk("imm_w_busy", {15'd0, w}, 16'd0);
        step();
        chk("imm_done_w", {15'd0, w}, 16'd1);
        chk("imm_done_strobes", strobes(), 16'd0);

        // MOV R1,#-2
        load = 1'b1; in = 16'hD1FE;
        step();
        load = 1'b0; s = 1'b1;
        step();
        s = 1'b0;
        step();
        chk("neg_write", strobes(), 16'b10000);
        chk("neg_writenum", {13'd0, writenum}, 16'd1);
        chk("neg_readnum", {13'd0, readnum}, 16'd1);
        chk("neg_sximm8", sximm8, 16'hFFFE);
        chk("neg_sximm5", sximm5, 16'hFFFE);
        step();
        chk("neg_done_w", {15'd0, w}, 16'd1);

        // ADD R2,R1,R0,LSL#1 : five busy cycles
        load = 1'b1; in = 16'hA148;
        step();
        load = 1'b0; s = 1'b1;
        step();
        s = 1'b0;
        chk("add_decode_w", {15'd0, w}, 16'd0);
        step();
        chk("add_geta_strobes", strobes(), 16'b01000);
        chk("add_geta_readnum", {13'd0, readnum}, 16'd1);
        chk("add_geta_w", {15'd0, w}, 16'd0);
        step();
        chk("add_getb_strobes", strobes(), 16'b00100);
        chk("add_getb_readnum", {13'd0, readnum}, 16'd0);
        chk("add_getb_shift", {14'd0, shift}, 16'b01);
        step();
        chk("add_alu_strobes", strobes(), 16'b00010);
        chk("add_alu_aluop", {14'd0, ALUop}, 16'b00);
        chk("add_alu_asel", {15'd0, asel}, 16'd0);
        chk("add_alu_bsel", {15'd0, bsel}, 16'd0);
        step();
        chk("add_wr_strobes", strobes(), 16'b10000);
        chk("add_wr_writenum", {13'd0, writenum}, 16'd2);
        chk("add_wr_vsel", {14'd0, vsel}, 16'b00);
        chk("add_wr_w", {15'd0, w}, 16'd0);
        step();
        chk("add_done_w", {15'd0, w}, 16'd1);

        // CMP R0,R1 : four busy cycles, status load only
        load = 1'b1; in = 16'hA801;
        step();
        load = 1'b0; s = 1'b1;
        step();
        s = 1'b0;
        chk("cmp_decode_write", {15'd0, write}, 16'd0);
        step();
        chk("cmp_geta_strobes", strobes(), 16'b01000);
        chk("cmp_geta_readnum", {13'd0, readnum}, 16'd0);
        step();
        chk("cmp_getb_strobes", strobes(), 16'b00100);
        chk("cmp_getb_readnum", {13'd0, readnum}, 16'd1);
        step();
        chk("cmp_alu_strobes", strobes(), 16'b00001);
        chk("cmp_alu_aluop", {14'd0, ALUop}, 16'b01);
        chk("cmp_alu_w", {15'd0, w}, 16'd0);
        step();
        chk("cmp_done_w", {15'd0, w}, 16'd1);
        chk("cmp_done_strobes", strobes(), 16'd0);

        // MVN R7,R1 : skips GET_A, A operand forced to zero
        load = 1'b1; in = 16'hB8E1;
        step();
        load = 1'b0; s = 1'b1;
        step();
        s = 1'b0;
        step();
        chk("mvn_getb_strobes", strobes(), 16'b00100);
        chk("mvn_getb_readnum", {13'd0, readnum}, 16'd1);
        step();
        chk("mvn_alu_strobes", strobes(), 16'b00010);
        chk("mvn_alu_asel", {15'd0, asel}, 16'd1);
        chk("mvn_alu_aluop", {14'd0, ALUop}, 16'b11);
        step();
        chk("mvn_wr_strobes", strobes(), 16'b10000);
        chk("mvn_wr_writenum", {13'd0, writenum}, 16'd7);
        step();
        chk("mvn_done_w", {15'd0, w}, 16'd1);

        // Undefined opcode acts as a one-cycle NOP; level-held s restarts
        load = 1'b1; in = 16'h0000;
        step();
        load = 1'b0; s = 1'b1;
        step();
        chk("nop_decode_w", {15'd0, w}, 16'd0);
        chk("nop_aluop", {14'd0, ALUop}, 16'b00);
        step();
        chk("nop_back_w", {15'd0, w}, 16'd1);
        chk("nop_strobes", strobes(), 16'd0);
        step();
        chk("nop_restart_w", {15'd0, w}, 16'd0);
        s = 1'b0;
        step();
        chk("nop_idle_w", {15'd0, w}, 16'd1);

        // ADD aborted by reset in GET_B; load outside WAIT is ignored
        load = 1'b1; in = 16'hA148;
        step();
        load = 1'b0; s = 1'b1;
        step();
        s = 1'b0;
        step();
        chk("abort_geta_loada", {15'd0, loada}, 16'd1);
        load = 1'b1; in = 16'hD0FF;
        step();
        chk("abort_ir_held", sximm8, 16'h0048);
        chk("abort_getb_loadb", {15'd0, loadb}, 16'd1);
        reset = 1'b0;
        step();
        chk("abort_w", {15'd0, w}, 16'd1);
        chk("abort_ir_zero", sximm8, 16'h0000);
        chk("abort_strobes", strobes(), 16'd0);
        reset = 1'b1; load = 1'b0;
        step();
        chk("abort_idle_w", {15'd0, w}, 16'd1);
        chk("abort_idle_write", {15'd0, write}, 16'd0);
        step();
        chk("abort_idle_write2", {15'd0, write}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
